// File: rtl/multi_stepper_sequencer.sv
// N-channel stepper dispense sequencer: drives each channel's 4-coil motor in turn for its latched step count.
// Optional macro HALF_STEP_EN selects the 8-phase half-step sequence; otherwise 4-phase full-step is used.
module multi_stepper_sequencer #(
    parameter int N_CH      = 3,
    parameter int CNT_W     = 10,
    parameter int STEP_DIV  = 2**19,
    parameter int GAP_TICKS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [N_CH*CNT_W-1:0] targets,
    input  logic [N_CH-1:0]       dirs,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            ch_idx,
    output logic [N_CH*4-1:0]     coils
);
    localparam int PRESC_W = $clog2(STEP_DIV);
    localparam int GAP_W   = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
    localparam int COIL_W  = N_CH * 4;
`ifdef HALF_STEP_EN
    localparam int PH_W = 3;
`else
    localparam int PH_W = 2;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [PRESC_W-1:0]   presc_r, presc_s;
    logic [CNT_W-1:0]     step_cnt_r, step_cnt_s;
    logic [PH_W-1:0]      phase_r, phase_s;
    logic [GAP_W-1:0]     gap_cnt_r, gap_cnt_s;
    logic [2:0]           ch_r, ch_s;
    logic [CNT_W-1:0]     tgt_in_s [8];
    logic [CNT_W-1:0]     tgt_r [8];
    logic [7:0]           dirs_r;
    logic [CNT_W-1:0]     cur_target_s;
    logic                 cur_dir_s;
    logic                 tick_s, last_ch_s, step_last_s, gap_last_s, accept_s;
    logic                 busy_s, done_s;
    logic [2:0]           ch_idx_s;
    logic [COIL_W-1:0]    coils_s;

    function automatic logic [3:0] coil_pattern(input logic [PH_W-1:0] ph);
        logic [3:0] pat;
`ifdef HALF_STEP_EN
        case (ph)
            3'd0:    pat = 4'b0001;
            3'd1:    pat = 4'b0011;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b1100;
            3'd6:    pat = 4'b1000;
            3'd7:    pat = 4'b1001;
            default: pat = 4'b0000;
        endcase
`else
        case (ph)
            2'd0:    pat = 4'b0001;
            2'd1:    pat = 4'b0010;
            2'd2:    pat = 4'b0100;
            2'd3:    pat = 4'b1000;
            default: pat = 4'b0000;
        endcase
`endif
        return pat;
    endfunction

    // Unused channel slots read as zero targets so the channel index never selects undefined data
    for (genvar g = 0; g < 8; g++) begin : g_tgt
        if (g < N_CH) begin : g_used
            assign tgt_in_s[g] = targets[g*CNT_W +: CNT_W];
        end else begin : g_unused
            assign tgt_in_s[g] = '0;
        end
    end

    assign tick_s       = (presc_r == PRESC_W'(STEP_DIV - 1));
    assign cur_target_s = tgt_r[ch_r];
    assign cur_dir_s    = dirs_r[ch_r];
    assign last_ch_s    = (ch_r == 3'(N_CH - 1));
    assign step_last_s  = tick_s && ((step_cnt_r + CNT_W'(1)) == cur_target_s);
    assign gap_last_s   = tick_s && ((32'(gap_cnt_r) + 32'd1) >= 32'(GAP_TICKS));
    assign accept_s     = (state_r == IDLE) && (state_s == LOAD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort wins over everything, including a start in IDLE
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) state_s = LOAD;
                    else       state_s = IDLE;
                end
                LOAD: begin
                    if (cur_target_s == '0) state_s = last_ch_s ? FIN : LOAD;
                    else                    state_s = RUN;
                end
                RUN: begin
                    if (step_last_s) begin
                        if (last_ch_s)           state_s = FIN;
                        else if (GAP_TICKS == 0) state_s = LOAD;
                        else                     state_s = GAP;
                    end else begin
                        state_s = RUN;
                    end
                end
                GAP: begin
                    if (gap_last_s) state_s = LOAD;
                    else            state_s = GAP;
                end
                FIN:     state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Datapath next values: prescaler, channel index, step/phase and gap counters
    always_comb begin
        presc_s    = presc_r;
        ch_s       = ch_r;
        step_cnt_s = step_cnt_r;
        phase_s    = phase_r;
        gap_cnt_s  = gap_cnt_r;

        if (state_r == IDLE || state_s == IDLE) presc_s = '0;
        else if (tick_s)                        presc_s = '0;
        else                                    presc_s = presc_r + PRESC_W'(1);

        if (state_s == IDLE)                            ch_s = 3'd0;
        else if (state_r != IDLE && state_s == LOAD)    ch_s = ch_r + 3'd1;
        else                                            ch_s = ch_r;

        if (state_s == LOAD || state_s == IDLE) begin
            step_cnt_s = '0;
            phase_s    = '0;
        end else if (state_r == RUN && tick_s) begin
            step_cnt_s = step_cnt_r + CNT_W'(1);
            phase_s    = cur_dir_s ? (phase_r - PH_W'(1)) : (phase_r + PH_W'(1));
        end else begin
            step_cnt_s = step_cnt_r;
            phase_s    = phase_r;
        end

        // A tick on the edge that enters GAP belongs to RUN, so the count starts fresh
        if (state_r != GAP) gap_cnt_s = '0;
        else if (tick_s)    gap_cnt_s = gap_cnt_r + GAP_W'(1);
        else                gap_cnt_s = gap_cnt_r;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r    <= '0;
            ch_r       <= 3'd0;
            step_cnt_r <= '0;
            phase_r    <= '0;
            gap_cnt_r  <= '0;
        end else begin
            presc_r    <= presc_s;
            ch_r       <= ch_s;
            step_cnt_r <= step_cnt_s;
            phase_r    <= phase_s;
            gap_cnt_r  <= gap_cnt_s;
        end
    end

    // Latch targets and directions on accept; later input changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) tgt_r[i] <= '0;
            dirs_r <= 8'd0;
        end else if (accept_s) begin
            for (int i = 0; i < 8; i++) tgt_r[i] <= tgt_in_s[i];
            dirs_r <= 8'(dirs);
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        busy_s   = (state_s != IDLE);
        done_s   = (state_s == FIN);
        ch_idx_s = ch_s;
        if (state_s == RUN) coils_s = COIL_W'(coil_pattern(phase_s)) << (32'(ch_s) * 32'd4);
        else                coils_s = '0;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            ch_idx <= 3'd0;
            coils  <= '0;
        end else begin
            busy   <= busy_s;
            done   <= done_s;
            ch_idx <= ch_idx_s;
            coils  <= coils_s;
        end
    end
endmodule

// File: tb/tb_multi_stepper_sequencer.sv
// Scoreboard bench for multi_stepper_sequencer: a timeline model predicts every busy cycle's outputs.
module tb_multi_stepper_sequencer;
    localparam int N_CH      = 3;
    localparam int CNT_W     = 10;
    localparam int STEP_DIV  = 4;
    localparam int GAP_TICKS = 2;
    localparam int CW        = N_CH * 4;
`ifdef HALF_STEP_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 4;
`endif

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [2:0]    ch;
        logic [CW-1:0] coils;
    } obs_t;

    logic                  clk = 1'b0;
    logic                  rst, start, abort;
    logic [N_CH*CNT_W-1:0] targets;
    logic [N_CH-1:0]       dirs;
    logic                  busy, done;
    logic [2:0]            ch_idx;
    logic [CW-1:0]         coils;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    obs_t exp_q[$];
    obs_t trace[$];
    int   run1_lo, run1_hi, gap_lo, gap_hi;
    int   tgv[N_CH];
    int   cut;

    always #5 clk = ~clk;

    multi_stepper_sequencer #(
        .N_CH(N_CH), .CNT_W(CNT_W), .STEP_DIV(STEP_DIV), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .targets(targets), .dirs(dirs),
        .busy(busy), .done(done), .ch_idx(ch_idx), .coils(coils)
    );

    // Coil pattern for a phase: one-hot walk, half-steps add the next coil on odd phases
    function automatic logic [3:0] pat(int p);
        logic [3:0] base;
        base = 4'b0001 << (NPH == 4 ? p : p / 2);
        if (NPH == 4 || p % 2 == 0) return base;
        return base | (4'b0001 << ((p / 2 + 1) % 4));
    endfunction

    // Ticks fall on every cycle number that is a multiple of STEP_DIV (cycle 1 follows accept)
    function automatic int next_tick(int k);
        return ((k + STEP_DIV - 1) / STEP_DIV) * STEP_DIV;
    endfunction

    task automatic build_trace(input int tg[N_CH], input logic [N_CH-1:0] dr);
        int   k, e, ph;
        obs_t o;
        trace.delete();
        run1_lo = 0; run1_hi = 0; gap_lo = 0; gap_hi = 0;
        k = 1;
        for (int i = 0; i < N_CH; i++) begin
            o.busy = 1'b1; o.done = 1'b0; o.ch = 3'(i); o.coils = '0;
            trace.push_back(o);
            k++;
            if (tg[i] > 0) begin
                ph = 0;
                if (i == 1) run1_lo = k;
                for (int s = 0; s < tg[i]; s++) begin
                    e = next_tick(k);
                    o.coils = CW'(pat(ph)) << (4 * i);
                    for (int c = k; c <= e; c++) trace.push_back(o);
                    ph = dr[i] ? (ph + NPH - 1) % NPH : (ph + 1) % NPH;
                    k = e + 1;
                end
                if (i == 1) run1_hi = k - 1;
                o.coils = '0;
                if (i < N_CH - 1) begin
                    if (i == 0) gap_lo = k;
                    for (int g = 0; g < GAP_TICKS; g++) begin
                        e = next_tick(k);
                        for (int c = k; c <= e; c++) trace.push_back(o);
                        k = e + 1;
                    end
                    if (i == 0) gap_hi = k - 1;
                end
            end
        end
        o.busy = 1'b1; o.done = 1'b1; o.ch = 3'(N_CH - 1); o.coils = '0;
        trace.push_back(o);
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < N_CH; i++) targets[i*CNT_W +: CNT_W] = CNT_W'($urandom);
        dirs = N_CH'($urandom);
    endtask

    // One sequence: cut_at > 0 raises abort (or rst) during that cycle; noise pulses start while busy
    task automatic run_seq(input int tg[N_CH], input logic [N_CH-1:0] dr,
                           input int cut_at, input bit use_rst, input bit noise);
        int n, bound;
        build_trace(tg, dr);
        n = (cut_at > 0) ? cut_at : trace.size();
        @(negedge clk);
        for (int i = 0; i < N_CH; i++) targets[i*CNT_W +: CNT_W] = CNT_W'(tg[i]);
        dirs  = dr;
        start = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(trace[i]);
        for (int m = 1; m <= n + 1; m++) begin
            @(negedge clk);
            start = (noise && m <= n) ? 1'($urandom_range(0, 1)) : 1'b0;
            randomize_inputs();
            if (m == cut_at) begin
                if (use_rst) rst = 1'b1;
                else         abort = 1'b1;
            end else begin
                rst   = 1'b0;
                abort = 1'b0;
            end
        end
        bound = 0;
        while (exp_q.size() != 0 && bound < 64) begin
            @(negedge clk);
            #1;
            bound++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predicted busy cycles never presented, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({busy, done, ch_idx, coils} !== '0) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b ch_idx=%0d coils=%b, required all zero",
                     name, busy, done, ch_idx, coils);
        end
    endtask

    // Monitor: every cycle with any active output consumes one predicted entry
    always @(negedge clk) begin
        obs_t got, want;
        if (mon_en) begin
            got.busy = busy; got.done = done; got.ch = ch_idx; got.coils = coils;
            if (got !== '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got busy=%b done=%b ch_idx=%0d coils=%b, required idle",
                             busy, done, ch_idx, coils);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL cycle_output: got busy=%b done=%b ch_idx=%0d coils=%b, required busy=%b done=%b ch_idx=%0d coils=%b",
                                 busy, done, ch_idx, coils, want.busy, want.done, want.ch, want.coils);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; targets = '0; dirs = '0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        tgv = '{7, 4, 2}; run_seq(tgv, 3'b000, 0, 1'b0, 1'b0);
        tgv = '{0, 3, 0}; run_seq(tgv, 3'b010, 0, 1'b0, 1'b0);
        tgv = '{5, 2, 3}; run_seq(tgv, 3'b101, 0, 1'b0, 1'b1);

        tgv = '{3, 6, 2};
        build_trace(tgv, 3'b000);
        cut = run1_lo + int'($urandom_range(0, run1_hi - run1_lo));
        run_seq(tgv, 3'b000, cut, 1'b0, 1'b0);
        check_idle("after_abort");

        tgv = '{2, 3, 1};
        build_trace(tgv, 3'b110);
        cut = gap_lo + int'($urandom_range(0, gap_hi - gap_lo));
        run_seq(tgv, 3'b110, cut, 1'b1, 1'b0);
        check_idle("after_rst");

        tgv = '{9, 0, 0}; run_seq(tgv, 3'b000, 0, 1'b0, 1'b0);
        tgv = '{0, 0, 0}; run_seq(tgv, 3'b000, 0, 1'b0, 1'b0);
        tgv = '{1, 1, 1}; run_seq(tgv, 3'b111, 0, 1'b0, 1'b1);

        @(negedge clk);
        start = 1'b1; abort = 1'b1; randomize_inputs();
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("abort_over_start");

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N_CH; i++)
                tgv[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            build_trace(tgv, 3'(r));
            cut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, trace.size())) : 0;
            run_seq(tgv, 3'(r), cut, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        tgv = '{1023, 0, 1}; run_seq(tgv, 3'b001, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
